// File: rtl/fib_frame_gen.sv
// Streams a 13-nibble test frame with a caller-chosen count of 4-bit Fibonacci values.
// Optional FIB_GEN_PARALLEL_EN adds frame_data[51:0] holding the whole frame in parallel.
module fib_frame_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  fib_count,
    input  logic [7:0]  seed,
    output logic        nib_valid,
    input  logic        nib_ready,
    output logic [3:0]  nib_data,
    output logic        nib_last,
    output logic        busy,
    output logic        done,
    output logic        expected_f,
    output logic        err
`ifdef FIB_GEN_PARALLEL_EN
    ,
    output logic [51:0] frame_data
`endif
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  rem_fib_q, rem_fib_d;
    logic [3:0]  rem_slots_q, rem_slots_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        expf_q, expf_d;
    logic        err_q, err_d;
    logic        accept, handshake, pick_fib;
    logic [3:0]  fib_val, nf_val, nib_val;
    logic [7:0]  lfsr_next;
`ifdef FIB_GEN_PARALLEL_EN
    logic [51:0] frame_q, frame_d;
`endif

    assign accept    = (state_q == IDLE) && start && (fib_count <= 4'd13);
    assign handshake = (state_q == SEND) && nib_ready;
    // Galois form of x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    assign lfsr_next = {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? 8'h71 : 8'h00);

    always_comb begin
        pick_fib = (rem_fib_q == rem_slots_q) || ((rem_fib_q != 4'd0) && lfsr_q[7]);
        case (lfsr_q[2:0])
            3'd0:    fib_val = 4'd0;
            3'd1:    fib_val = 4'd1;
            3'd2:    fib_val = 4'd2;
            3'd3:    fib_val = 4'd3;
            3'd4:    fib_val = 4'd5;
            3'd5:    fib_val = 4'd8;
            3'd6:    fib_val = 4'd13;
            default: fib_val = 4'd0;
        endcase
        case (lfsr_q[6:3])
            4'd0, 4'd9:   nf_val = 4'd4;
            4'd1, 4'd10:  nf_val = 4'd6;
            4'd2, 4'd11:  nf_val = 4'd7;
            4'd3, 4'd12:  nf_val = 4'd9;
            4'd4, 4'd13:  nf_val = 4'd10;
            4'd5, 4'd14:  nf_val = 4'd11;
            4'd6, 4'd15:  nf_val = 4'd12;
            4'd7:         nf_val = 4'd14;
            default:      nf_val = 4'd15;
        endcase
        nib_val = pick_fib ? fib_val : nf_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (handshake && (rem_slots_q == 4'd1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nib_valid  = (state_q == SEND);
        nib_last   = (state_q == SEND) && (rem_slots_q == 4'd1);
        nib_data   = (state_q == SEND) ? nib_val : '0;
        busy       = (state_q == SEND) || (state_q == DONE);
        done       = (state_q == DONE);
        expected_f = expf_q;
        err        = err_q;
    end

    always_comb begin
        rem_fib_d   = rem_fib_q;
        rem_slots_d = rem_slots_q;
        lfsr_d      = lfsr_q;
        expf_d      = expf_q;
        err_d       = (state_q == IDLE) && start && (fib_count > 4'd13);
`ifdef FIB_GEN_PARALLEL_EN
        frame_d     = frame_q;
`endif
        if (accept) begin
            rem_fib_d   = fib_count;
            rem_slots_d = 4'd13;
            lfsr_d      = (seed == 8'h00) ? 8'hA5 : seed;
            expf_d      = (fib_count >= 4'd7);
`ifdef FIB_GEN_PARALLEL_EN
            frame_d     = '0;
`endif
        end else if (handshake) begin
            rem_slots_d = rem_slots_q - 4'd1;
            if (pick_fib) rem_fib_d = rem_fib_q - 4'd1;
            lfsr_d = lfsr_next;
`ifdef FIB_GEN_PARALLEL_EN
            // Slot index counts up from nibble 1 as rem_slots counts down from 13.
            for (int unsigned k = 0; k < 13; k++) begin
                if (rem_slots_q == 4'(13 - k)) frame_d[4*k +: 4] = nib_val;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_fib_q   <= '0;
            rem_slots_q <= '0;
            lfsr_q      <= 8'hA5;
            expf_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef FIB_GEN_PARALLEL_EN
            frame_q     <= '0;
`endif
        end else begin
            rem_fib_q   <= rem_fib_d;
            rem_slots_q <= rem_slots_d;
            lfsr_q      <= lfsr_d;
            expf_q      <= expf_d;
            err_q       <= err_d;
`ifdef FIB_GEN_PARALLEL_EN
            frame_q     <= frame_d;
`endif
        end
    end

`ifdef FIB_GEN_PARALLEL_EN
    assign frame_data = frame_q;
`endif

endmodule

// File: tb/tb_fib_frame_gen.sv
// Scoreboard bench for fib_frame_gen: a frame-level reference model queues expected nibbles,
// a negedge monitor pops and compares them on every handshake.
module tb_fib_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  fib_count = '0;
    logic [7:0]  seed = '0;
    logic        nib_ready = 1'b0;
    logic        nib_valid, nib_last, busy, done, expected_f, err;
    logic [3:0]  nib_data;
`ifdef FIB_GEN_PARALLEL_EN
    logic [51:0] frame_data;
`endif

    fib_frame_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .fib_count  (fib_count),
        .seed       (seed),
        .nib_valid  (nib_valid),
        .nib_ready  (nib_ready),
        .nib_data   (nib_data),
        .nib_last   (nib_last),
        .busy       (busy),
        .done       (done),
        .expected_f (expected_f),
        .err        (err)
`ifdef FIB_GEN_PARALLEL_EN
        ,
        .frame_data (frame_data)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  exp_q[$];
    logic [4:0]  mon_e;
    logic [3:0]  act_frame[13];
    int          xfer_cnt = 0;
    bit          pend_done = 0, pend_idle = 0, idle_seen = 0, hold_pend = 0;
    logic [3:0]  hold_data;
    logic        hold_last;
    logic        exp_ef = 1'b0;
    logic [51:0] exp_packed = '0;
    int          fibtab[8]  = '{0, 1, 2, 3, 5, 8, 13, 0};
    int          nftab[16]  = '{4, 6, 7, 9, 10, 11, 12, 14, 15, 4, 6, 7, 9, 10, 11, 12};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lfsr_step(input int s);
        int v;
        v = s * 2;
        if (v >= 256) v = (v - 256) ^ 'h71;
        return v;
    endfunction

    function automatic int count_fib();
        int n = 0;
        for (int i = 0; i < 13; i++)
            if (act_frame[i] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13}) n++;
        return n;
    endfunction

    function automatic logic [51:0] pack_frame();
        logic [51:0] p = '0;
        for (int i = 0; i < 13; i++) p[4*i +: 4] = act_frame[i];
        return p;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pend_done = 0;
            pend_idle = 0;
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", nib_valid, 1);
                chk("hold_data", nib_data, hold_data);
                chk("hold_last", nib_last, hold_last);
            end
            if (pend_idle) begin
                chk("post_done_busy", busy, 0);
                chk("post_done_done", done, 0);
                chk("post_done_valid", nib_valid, 0);
                pend_idle = 0;
                idle_seen = 1;
            end
            if (pend_done) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                chk("expected_f", expected_f, exp_ef);
`ifdef FIB_GEN_PARALLEL_EN
                chk("frame_data_at_done", frame_data, exp_packed);
`endif
                pend_done = 0;
                pend_idle = 1;
            end else if (done) begin
                chk("spurious_done", done, 0);
            end
            if (nib_valid && nib_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_nibble", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("nib_data", nib_data, mon_e[3:0]);
                    chk("nib_last", nib_last, mon_e[4]);
                    if (xfer_cnt < 13) act_frame[xfer_cnt] = nib_data;
                    xfer_cnt++;
                    if (mon_e[4]) pend_done = 1;
                end
            end
            hold_pend = nib_valid && !nib_ready;
            hold_data = nib_data;
            hold_last = nib_last;
        end
    end

    // mode: 0 ready high, 1 random ready and stray starts, 2 stall at 4th nibble, 3 reset after 6th
    task automatic run_frame(input logic [3:0] fc, input logic [7:0] sd, input int mode);
        int s, rf, cyc, stall;
        bit f, poked;
        logic [3:0] v;
        s  = (sd == 8'h00) ? 'hA5 : int'(sd);
        rf = int'(fc);
        exp_packed = '0;
        for (int i = 0; i < 13; i++) begin
            if (rf == 13 - i)  f = 1;
            else if (rf == 0)  f = 0;
            else               f = (s >= 128);
            v = f ? 4'(fibtab[s % 8]) : 4'(nftab[(s / 8) % 16]);
            if (f) rf--;
            exp_q.push_back({(i == 12), v});
            exp_packed[4*i +: 4] = v;
            s = lfsr_step(s);
        end
        exp_ef    = (fc >= 4'd7);
        xfer_cnt  = 0;
        idle_seen = 0;
        fib_count = fc;
        seed      = sd;
        start     = 1'b1;
        nib_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        chk("pre_accept_valid", nib_valid, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("first_valid", nib_valid, 1);
        chk("busy_send", busy, 1);
        cyc = 0; stall = 0; poked = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (idle_seen) break;
            if (cyc > 200) begin
                chk("frame_timeout", 0, 1);
                break;
            end
            case (mode)
                1: begin
                    nib_ready = ($urandom_range(0, 3) != 0);
                    if (xfer_cnt == 13) begin
                        start = !poked;
                        poked = 1;
                    end else begin
                        start = ($urandom_range(0, 4) == 0);
                    end
                    fib_count = 4'($urandom);
                    seed      = 8'($urandom);
                end
                2: begin
                    if (xfer_cnt == 3 && stall < 5) begin
                        nib_ready = 1'b0;
                        stall++;
                    end else begin
                        nib_ready = 1'b1;
                    end
                end
                3: begin
                    if (xfer_cnt == 6) begin
                        rst_n = 1'b0;
                        nib_ready = 1'b0;
                        break;
                    end
                    nib_ready = 1'b1;
                end
                default: nib_ready = 1'b1;
            endcase
        end
        start = 1'b0;
        if (mode != 3) begin
            chk("xfer_count", xfer_cnt, 13);
            chk("queue_drained", exp_q.size(), 0);
        end
    endtask

    logic [51:0] saved;
    logic [23:0] saved6;
    int          fc_r;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", nib_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ef", expected_f, 0);
        chk("rst_last", nib_last, 0);
        chk("rst_data", nib_data, 0);
`ifdef FIB_GEN_PARALLEL_EN
        chk("rst_frame_data", frame_data, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(4'd7, 8'h00, 0);
        chk("zero_seed_fib_count", count_fib(), 7);
        saved = pack_frame();
        run_frame(4'd7, 8'hA5, 0);
        chk("seed0_equals_A5", pack_frame(), saved);

        run_frame(4'd0, 8'h3C, 0);
        chk("lower_bound_fib_count", count_fib(), 0);
        run_frame(4'd13, 8'h5A, 0);
        chk("upper_bound_fib_count", count_fib(), 13);
        run_frame(4'd6, 8'h77, 0);
        chk("six_fib_count", count_fib(), 6);

        run_frame(4'd9, 8'hC3, 0);
        saved = pack_frame();
        run_frame(4'd9, 8'hC3, 2);
        chk("backpressure_same_frame", pack_frame(), saved);

        for (int e = 14; e <= 15; e++) begin
            fib_count = 4'(e);
            seed      = 8'h11;
            start     = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("err_pulse", err, 1);
            chk("err_busy", busy, 0);
            chk("err_valid", nib_valid, 0);
            @(negedge clk);
            chk("err_cleared", err, 0);
            chk("err_still_idle", busy, 0);
            @(posedge clk); #1;
        end

        repeat (8) begin
            fc_r = $urandom_range(0, 13);
            run_frame(4'(fc_r), 8'($urandom), 1);
            chk("random_fib_count", count_fib(), fc_r);
        end

        run_frame(4'd10, 8'hA5, 3);
        saved6 = pack_frame()[23:0];
        @(posedge clk); #1;
        chk("midrst_valid", nib_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ef", expected_f, 0);
        chk("midrst_last", nib_last, 0);
        chk("midrst_data", nib_data, 0);
        chk("midrst_err", err, 0);
`ifdef FIB_GEN_PARALLEL_EN
        chk("midrst_frame_data", frame_data, 0);
`endif
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(4'd10, 8'hA5, 0);
        chk("restart_same_prefix", pack_frame()[23:0], saved6);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
